hog_block_assembler: RTL and testbench

Assembles 2x2 HOG blocks from a raster-order stream of cell histograms, one cell per valid beat. Each complete 2x2 neighbourhood (stride one cell) is presented on `bin_a`..`bin_d` with `o_valid`. The block sits directly upstream of the block-normalisation stage, and its outputs connect port-for-port to that stage's `bin_*`/`i_valid` inputs. The default geometry is 80x60 cells (640x480, 8x8-pixel cells), which gives 79*59 = 4661 blocks per frame.

---
 rtl/hog_block_assembler_if.sv | 39 +++
 rtl/hog_block_assembler.sv | 101 ++++++++++
 tb/tb_hog_block_assembler.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/hog_block_assembler_if.sv
// Cell-stream in / 2x2-block out bundle for the HOG block assembler.
// slave = assembler side, master = the producer/consumer around it.
interface hog_block_assembler_if #(
    parameter int W = 32
);
    logic [9*W-1:0] cell_hist;
    logic           i_valid;
    logic           clear;
    logic [9*W-1:0] bin_a;
    logic [9*W-1:0] bin_b;
    logic [9*W-1:0] bin_c;
    logic [9*W-1:0] bin_d;
    logic           o_valid;
    logic           frame_done;

    modport slave (
        input  cell_hist,
        input  i_valid,
        input  clear,
        output bin_a,
        output bin_b,
        output bin_c,
        output bin_d,
        output o_valid,
        output frame_done
    );

    modport master (
        output cell_hist,
        output i_valid,
        output clear,
        input  bin_a,
        input  bin_b,
        input  bin_c,
        input  bin_d,
        input  o_valid,
        input  frame_done
    );
endinterface

// File: rtl/hog_block_assembler.sv
// Builds 2x2 stride-1 HOG blocks from a raster stream of 9-bin cell histograms.
// Latency: one cycle from the i_valid of the bottom-right cell to o_valid.
// No backpressure: one cell per cycle accepted, downstream always takes the block.
module hog_block_assembler #(
    parameter int BIN_I   = 16,
    parameter int BIN_F   = 16,
    parameter int CELLS_X = 80,
    parameter int CELLS_Y = 60
) (
    input  logic                   clk,
    input  logic                   rst,
    hog_block_assembler_if.slave   bus
);
    localparam int W  = BIN_I + BIN_F;
    localparam int HW = 9 * W;
    localparam int CW = $clog2(CELLS_X);
    localparam int RW = $clog2(CELLS_Y);

    typedef logic [HW-1:0] hist_t;

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Previous cell row, one entry per column; read-before-write at col.
    hist_t line_buf [CELLS_X];

    hist_t left_cur;
    hist_t left_up;
    hist_t up_rd;

    hist_t bin_a_q;
    hist_t bin_b_q;
    hist_t bin_c_q;
    hist_t bin_d_q;
    logic  o_valid_q;
    logic  frame_done_q;

    logic accept;
    logic emit;
    logic last_col;
    logic last_row;

    // clear wins over a coincident cell: that cell is dropped entirely.
    assign accept   = bus.i_valid && !bus.clear;
    assign last_col = (col == CW'(CELLS_X - 1));
    assign last_row = (row == RW'(CELLS_Y - 1));
    assign emit     = accept && (col != '0) && (row != '0);
    assign up_rd    = line_buf[col];

    always_ff @(posedge clk) begin
        if (!rst) begin
            col          <= '0;
            row          <= '0;
            bin_a_q      <= '0;
            bin_b_q      <= '0;
            bin_c_q      <= '0;
            bin_d_q      <= '0;
            o_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            o_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
            if (bus.clear) begin
                col <= '0;
                row <= '0;
            end else if (bus.i_valid) begin
                if (emit) begin
                    bin_a_q      <= left_up;
                    bin_b_q      <= up_rd;
                    bin_c_q      <= left_cur;
                    bin_d_q      <= bus.cell_hist;
                    o_valid_q    <= 1'b1;
                    frame_done_q <= last_col && last_row;
                end
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    // Data storage is never reset: row 0 of every frame rewrites each entry
    // before any emit can read it, and column 0 never emits.
    always_ff @(posedge clk) begin
        if (rst && accept) begin
            line_buf[col] <= bus.cell_hist;
            left_cur      <= bus.cell_hist;
            left_up       <= up_rd;
        end
    end

    assign bus.bin_a      = bin_a_q;
    assign bus.bin_b      = bin_b_q;
    assign bus.bin_c      = bin_c_q;
    assign bus.bin_d      = bin_d_q;
    assign bus.o_valid    = o_valid_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_hog_block_assembler.sv
// Scoreboard bench: a frame-grid model predicts every 2x2 block; a monitor
// pops and compares each o_valid beat, including the exact emit cycle.
module tb_hog_block_assembler;
    localparam int CX = 80;
    localparam int CY = 60;
    localparam int NB = (CX - 1) * (CY - 1);
    localparam int HW = 9 * 32;

    typedef logic [HW-1:0] hist_t;
    typedef struct {
        hist_t a;
        hist_t b;
        hist_t c;
        hist_t d;
        bit    fd;
        int    cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    hog_block_assembler_if #(.W(32)) bus ();

    hog_block_assembler #(
        .BIN_I(16), .BIN_F(16), .CELLS_X(CX), .CELLS_Y(CY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    int    nblk = 0;
    int    nfd = 0;
    exp_t  exp_q[$];
    hist_t grid [CY][CX];
    int    pos = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input hist_t act, input hist_t expv);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every o_valid beat must match the oldest predicted block.
    always @(negedge clk) begin
        if (bus.frame_done && !bus.o_valid)
            chk(1'b0, "frame_done_without_valid", 1, 0);
        if (bus.o_valid) begin
            if (exp_q.size() == 0) begin
                chk(1'b0, "unexpected_o_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk(cyc == e.cyc, "emit_cycle", hist_t'(cyc), hist_t'(e.cyc));
                chk(bus.bin_a == e.a, "bin_a", bus.bin_a, e.a);
                chk(bus.bin_b == e.b, "bin_b", bus.bin_b, e.b);
                chk(bus.bin_c == e.c, "bin_c", bus.bin_c, e.c);
                chk(bus.bin_d == e.d, "bin_d", bus.bin_d, e.d);
                chk(bus.frame_done == e.fd, "frame_done", hist_t'(bus.frame_done), hist_t'(e.fd));
                nblk++;
                if (bus.frame_done) nfd++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: linear cell index -> (x,y); a block exists when both x and y are >= 1.
    task automatic send(input hist_t v, input int gap, input bit clr);
        int x;
        int y;
        x = pos % CX;
        y = pos / CX;
        bus.cell_hist = v;
        bus.i_valid   = 1'b1;
        bus.clear     = clr;
        if (clr) begin
            pos = 0;
        end else begin
            grid[y][x] = v;
            if (x >= 1 && y >= 1) begin
                exp_t e;
                e.a   = grid[y-1][x-1];
                e.b   = grid[y-1][x];
                e.c   = grid[y][x-1];
                e.d   = v;
                e.fd  = (x == CX - 1) && (y == CY - 1);
                e.cyc = cyc + 1;
                exp_q.push_back(e);
            end
            pos = (pos + 1) % (CX * CY);
        end
        step();
        bus.i_valid = 1'b0;
        bus.clear   = 1'b0;
        repeat (gap) step();
    endtask

    function automatic hist_t mk(input int x, input int y, input int off, input int mode);
        hist_t h;
        h = '0;
        for (int k = 0; k < 9; k++) begin
            case (mode)
                0:       h[k*32 +: 32] = 32'(x + 100 * y + off) << 16;
                1:       h[k*32 +: 32] = 32'(x + 100 * y + 10000 * k);
                default: h[k*32 +: 32] = $urandom;
            endcase
        end
        return h;
    endfunction

    task automatic run_cells(input int count, input int mode, input int off, input int maxgap);
        for (int i = 0; i < count; i++) begin
            int x;
            int y;
            x = pos % CX;
            y = pos / CX;
            send(mk(x, y, off, mode), (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0, 1'b0);
        end
    endtask

    task automatic frame_begin();
        nblk = 0;
        nfd  = 0;
    endtask

    task automatic frame_end(input string tag);
        step();
        step();
        chk(nblk == NB, {tag, "_block_count"}, hist_t'(nblk), hist_t'(NB));
        chk(nfd == 1, {tag, "_frame_done_count"}, hist_t'(nfd), 1);
        chk(exp_q.size() == 0, {tag, "_pending_blocks"}, hist_t'(exp_q.size()), 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk(bus.bin_a == '0, {tag, "_bin_a"}, bus.bin_a, 0);
        chk(bus.bin_b == '0, {tag, "_bin_b"}, bus.bin_b, 0);
        chk(bus.bin_c == '0, {tag, "_bin_c"}, bus.bin_c, 0);
        chk(bus.bin_d == '0, {tag, "_bin_d"}, bus.bin_d, 0);
        chk(bus.o_valid == 1'b0, {tag, "_o_valid"}, hist_t'(bus.o_valid), 0);
        chk(bus.frame_done == 1'b0, {tag, "_frame_done"}, hist_t'(bus.frame_done), 0);
    endtask

    initial begin
        bus.cell_hist = '0;
        bus.i_valid   = 1'b0;
        bus.clear     = 1'b0;
        rst = 1'b0;
        repeat (3) step();
        chk_zero_outputs("reset");
        rst = 1'b1;
        step();

        // Full frame, back-to-back, bins = x + 100y in the integer part.
        frame_begin();
        run_cells(CX * CY, 0, 0, 0);
        frame_end("frame_b2b");

        // Same frame with random idle gaps.
        frame_begin();
        run_cells(CX * CY, 0, 0, 5);
        frame_end("frame_gaps");

        // Two consecutive frames, second offset by 10000.
        frame_begin();
        run_cells(CX * CY, 0, 0, 0);
        frame_end("frame_pair1");
        frame_begin();
        run_cells(CX * CY, 0, 10000, 0);
        frame_end("frame_pair2");

        // Clear coincident with cell (40,30), then a fresh frame.
        run_cells(30 * CX + 40, 0, 0, 0);
        send(mk(40, 30, 0, 0), 0, 1'b1);
        chk(bus.o_valid == 1'b0, "clear_o_valid", hist_t'(bus.o_valid), 0);
        chk(bus.frame_done == 1'b0, "clear_frame_done", hist_t'(bus.frame_done), 0);
        frame_begin();
        run_cells(CX * CY, 0, 0, 0);
        frame_end("after_clear");

        // Reset pulse mid-row 5, then a fresh frame.
        run_cells(5 * CX + 30, 0, 0, 0);
        rst = 1'b0;
        step();
        chk_zero_outputs("mid_reset");
        rst = 1'b1;
        pos = 0;
        frame_begin();
        run_cells(CX * CY, 0, 0, 0);
        frame_end("after_reset");

        // Per-lane distinct values to catch lane swaps.
        frame_begin();
        run_cells(CX * CY, 1, 0, 0);
        frame_end("per_bin");

        // Random bin contents with occasional gaps.
        frame_begin();
        run_cells(CX * CY, 2, 0, 1);
        frame_end("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
